fetch_stage: RTL

Instruction-fetch stage of the five-stage RISC-V pipeline: owns the program counter, drives the instruction-memory address and loads the IF/ID pipeline register that feeds the decode stage. Decode splits `if_id_instr` to produce the opcode for the main controller. The stage honours load-use stalls from the hazard unit and redirects from the branch unit. It freezes permanently when decode reports the HALT pseudo-instruction.

---
 rtl/pipeline_pkg.sv | 33 +++
 rtl/fetch_stage_if_id_reg.sv | 25 ++
 rtl/fetch_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types and constants
package pipeline_pkg;

    // Widths the shared IF/ID record is built with; stage parameters default to these.
    localparam int IF_ID_PC_W  = 9;
    localparam int IF_ID_INS_W = 32;

    // addi x0, x0, 0
    localparam logic [IF_ID_INS_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [IF_ID_PC_W-1:0]  pc;
        logic [IF_ID_PC_W-1:0]  pc4;
        logic [IF_ID_INS_W-1:0] instr;
        logic                   valid;
    } if_id_t;

    // Empty IF/ID slot: NOP with zeroed PCs so decode sees a harmless instruction.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with flush/hold/load
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    // Flush beats hold beats load; with none asserted the register keeps its value.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            q <= if_id_bubble();
        end else if (hold) begin
            q <= q;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, next-PC mux, halt FSM, IF/ID
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int              PC_W     = IF_ID_PC_W,
    parameter int              INS_W    = IF_ID_INS_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic [PC_W-1:0]  if_id_pc,
    output logic [PC_W-1:0]  if_id_pc4,
    output logic [INS_W-1:0] if_id_instr,
    output logic             if_id_valid,
    output logic             halted,
    output logic [31:0]      fetch_count
);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  target_aligned;
    logic [31:0]      count_q;
    logic             count_inc;
    logic             ifid_load, ifid_flush, ifid_hold;
    logic             halt_eff;
    if_id_t           ifid_d, ifid_q;

    assign pc_plus4       = pc_q + PC_W'(4);
    assign target_aligned = branch_target & ~PC_W'(3);

    // A redirect means the IF/ID instruction is on the wrong path, so its halt is void.
    assign halt_eff = halt & ifid_q.valid & ~pc_sel;

    assign ifid_d.pc    = pc_q;
    assign ifid_d.pc4   = pc_plus4;
    assign ifid_d.instr = imem_rdata;
    assign ifid_d.valid = 1'b1;

    // Next-state, next-PC and IF/ID control: redirect > halt > stall > fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        count_inc  = 1'b0;
        case (state_q)
            RUN: begin
                if (pc_sel) begin
                    pc_d       = target_aligned;
                    ifid_flush = 1'b1;
                end else if (halt_eff) begin
                    state_d    = HALTED;
                    ifid_flush = 1'b1;
                end else if (stall) begin
                    ifid_hold  = 1'b1;
                end else begin
                    pc_d       = pc_plus4;
                    ifid_load  = 1'b1;
                    count_inc  = 1'b1;
                end
            end
            HALTED: begin
                ifid_hold = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC and fetch counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (count_inc) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .flush (ifid_flush),
        .hold  (ifid_hold),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imem_addr   = pc_q;
    assign if_id_pc    = ifid_q.pc;
    assign if_id_pc4   = ifid_q.pc4;
    assign if_id_instr = ifid_q.instr;
    assign if_id_valid = ifid_q.valid;
    assign halted      = (state_q == HALTED);
    assign fetch_count = count_q;

endmodule
